// File: rtl/tama_pkg.sv
// Shared definitions for the pet-care logic: need indices, level limits and the
// scheduler FSM states.
package tama_pkg;

  localparam int unsigned NEED_HUNGER    = 0;
  localparam int unsigned NEED_HAPPINESS = 1;
  localparam int unsigned NEED_HEALTH    = 2;
  localparam int unsigned NEED_HYGIENE   = 3;
  localparam int unsigned NEED_ENERGY    = 4;
  localparam int unsigned NEED_SOCIAL    = 5;

  localparam int unsigned NEED_NUM = 6;
  localparam logic [3:0]  NEED_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DEAD
  } state_e;

  // Modulo-6 successor of a need index; out-of-range values fold back to 0.
  function automatic logic [2:0] need_next(input logic [2:0] i);
    return (i >= 3'd5) ? 3'd0 : i + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter6.sv
// Combinational round-robin pick over six requesters, searching upward from the
// requester after the last winner.
module rr_arbiter6
  import tama_pkg::*;
(
  input  logic [5:0] req,
  input  logic [2:0] last,
  output logic [5:0] gnt,
  output logic [2:0] index,
  output logic       valid
);

  logic [2:0] w_cand;

  always_comb begin
    gnt    = 6'd0;
    index  = 3'd0;
    valid  = 1'b0;
    w_cand = last;
    for (int k = 0; k < 6; k++) begin
      w_cand = need_next(w_cand);
      if (!valid && req[w_cand]) begin
        valid       = 1'b1;
        index       = w_cand;
        gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/care_scheduler.sv
// Owns the six need levels: ages them on a round-robin decay tick and serves
// care requests one at a time, latching death when any need reaches the maximum.
module care_scheduler
  import tama_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned ACTION_CYCLES = 4,
  parameter int unsigned CARE_AMOUNT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  output logic [5:0] grant,
  output logic       busy,
  output logic [3:0] hunger,
  output logic [3:0] happiness,
  output logic [3:0] health,
  output logic [3:0] hygiene,
  output logic [3:0] energy,
  output logic [3:0] social,
  output logic       dead
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW   = (ACTION_CYCLES > 1) ? $clog2(ACTION_CYCLES) : 1;
  localparam logic [4:0]  CareAmt = 5'(CARE_AMOUNT);

  state_e            r_state, w_state_d;
  logic [PrescW-1:0] r_presc, w_presc_d;
  logic [2:0]        r_ptr, w_ptr_d;
  logic [2:0]        r_last, w_last_d;
  logic [5:0]        r_grant, w_grant_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [3:0]        r_need   [NEED_NUM];
  logic [3:0]        w_need_d [NEED_NUM];
  logic [4:0]        w_sum    [NEED_NUM];

  logic       w_fatal, w_halt, w_tick, w_care;
  logic [5:0] w_arb_gnt;
  logic [2:0] w_arb_idx;
  logic       w_arb_valid;

  rr_arbiter6 u_arb (
    .req   (req),
    .last  (r_last),
    .gnt   (w_arb_gnt),
    .index (w_arb_idx),
    .valid (w_arb_valid)
  );

  always_comb begin
    w_fatal = 1'b0;
    for (int i = 0; i < NEED_NUM; i++) begin
      if (r_need[i] == NEED_MAX) w_fatal = 1'b1;
    end
  end

  // A need at the maximum freezes everything already, one edge before DEAD is entered.
  assign w_halt = w_fatal || (r_state == DEAD);
  assign w_tick = !w_halt && (r_presc == PrescW'(TICK_DIV - 1));

  always_comb begin
    w_presc_d = r_presc;
    w_ptr_d   = r_ptr;
    if (!w_halt) begin
      w_presc_d = w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) w_ptr_d = need_next(r_ptr);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_cnt_d   = r_cnt;
    w_last_d  = r_last;
    w_care    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fatal) begin
          w_state_d = DEAD;
        end else if (w_arb_valid) begin
          w_state_d = SERVE;
          w_grant_d = w_arb_gnt;
          w_last_d  = w_arb_idx;
          w_cnt_d   = '0;
        end
      end
      SERVE: begin
        if (w_fatal) begin
          w_state_d = DEAD;
          w_grant_d = 6'd0;
        end else if (r_cnt == CntW'(ACTION_CYCLES - 1)) begin
          w_state_d = IDLE;
          w_grant_d = 6'd0;
          w_care    = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      DEAD: begin
        w_grant_d = 6'd0;
      end
      default: begin
        w_state_d = IDLE;
        w_grant_d = 6'd0;
      end
    endcase
  end

  // Decay is applied before care so a coinciding tick is absorbed by the decrement.
  always_comb begin
    for (int i = 0; i < NEED_NUM; i++) begin
      w_sum[i] = {1'b0, r_need[i]};
      if (w_tick && (r_ptr == 3'(i))) begin
        w_sum[i] = (w_sum[i] >= {1'b0, NEED_MAX}) ? {1'b0, NEED_MAX} : w_sum[i] + 5'd1;
      end
      if (w_care && (r_last == 3'(i))) begin
        w_sum[i] = (w_sum[i] >= CareAmt) ? w_sum[i] - CareAmt : 5'd0;
      end
      w_need_d[i] = w_sum[i][3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_ptr   <= 3'd0;
      r_last  <= 3'd5;
      r_grant <= 6'd0;
      r_cnt   <= '0;
      for (int i = 0; i < NEED_NUM; i++) r_need[i] <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_presc <= w_presc_d;
      r_ptr   <= w_ptr_d;
      r_last  <= w_last_d;
      r_grant <= w_grant_d;
      r_cnt   <= w_cnt_d;
      for (int i = 0; i < NEED_NUM; i++) r_need[i] <= w_need_d[i];
    end
  end

  assign grant     = r_grant;
  assign busy      = |r_grant;
  assign dead      = (r_state == DEAD);
  assign hunger    = r_need[NEED_HUNGER];
  assign happiness = r_need[NEED_HAPPINESS];
  assign health    = r_need[NEED_HEALTH];
  assign hygiene   = r_need[NEED_HYGIENE];
  assign energy    = r_need[NEED_ENERGY];
  assign social    = r_need[NEED_SOCIAL];

endmodule

// File: doc/care_scheduler.md
# care_scheduler

Owns the six need levels of the pet (hunger, happiness, health, hygiene, energy, social) and sequences every change to them. It ages the needs on a slow round-robin tick and serves care requests from the button/UI logic one at a time through a round-robin arbiter. Its need outputs feed the status/state-evaluation logic directly. Level convention: 0 = fully satisfied, 15 = fatal.

## Interface
Parameters:
- TICK_DIV, default 1000: clock cycles per decay tick (≥2).
- ACTION_CYCLES, default 4: cycles one care action occupies (≥1).
- CARE_AMOUNT, default 4: amount subtracted from the served need (1..15).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  6  level care requests; bit i maps to need i (0 hunger, 1 happiness, 2 health, 3 hygiene, 4 energy, 5 social).
- grant  out  6  one-hot; held high for the whole action being served.
- busy  out  1  high while an action is in progress (equals |grant).
- hunger, happiness, health, hygiene, energy, social  out  4 each  registered need levels.
- dead  out  1  latched fatal flag.

## Operation
- Reset values: all needs 0, grant 0, busy 0, dead 0, prescaler 0, decay pointer 0, round-robin last-grant = 5, FSM in IDLE.
- Prescaler: counts 0..TICK_DIV-1 and wraps. A tick fires on the wrap cycle.
- On each tick, the need at the decay pointer increments by 1, saturating at 15. The pointer then advances 0→5 and wraps to 0. Each need therefore ages once every 6 ticks.
- FSM states: IDLE, SERVE, DEAD.
  - IDLE → SERVE when req≠0. The winner is the first set bit searching from last-grant+1 upward, mod 6. last-grant is updated to the winner, grant is loaded with its one-hot, and the action counter is cleared.
  - SERVE lasts exactly ACTION_CYCLES cycles. On its final cycle the served need is set to max(0, n' − CARE_AMOUNT), grant is cleared, and the FSM returns to IDLE.
  - req is not re-sampled during SERVE. A requester still asserting after its grant ends is served again after the other pending requesters.
  - Any state → DEAD when any need register equals 15. DEAD is absorbing; only rst leaves it.
- Simultaneous decay tick and care update on the same need in the same cycle: n' = min(15, n+1), and the result is max(0, n' − CARE_AMOUNT). A tick on a different need proceeds independently.
- In DEAD:
  - dead = 1, grant = 0, busy = 0.
  - Prescaler and decay are frozen and needs hold their values.
  - req is ignored.
  - An action aborted by death applies no decrement.
- All arithmetic uses 5-bit intermediates, so saturation never wraps.

## Timing
- Request sampled in IDLE at edge t → grant/busy high for cycles t+1 .. t+ACTION_CYCLES.
- Need decrement is visible from cycle t+ACTION_CYCLES+1, in the same cycle grant falls.
- There is at least one IDLE cycle between consecutive grants, so back-to-back service period = ACTION_CYCLES+1.
- A need register reaches 15 at edge e → dead = 1 and the FSM is in DEAD from edge e+1. A SERVE in progress at e+1 is aborted with no decrement.
- rst assertion clears all outputs immediately (asynchronously), including mid-SERVE. Release is synchronous to clk.

## Structure
- Shared package tama_pkg holds:
  - need index constants NEED_HUNGER=0 .. NEED_SOCIAL=5;
  - NEED_NUM=6, NEED_MAX=4'd15;
  - the FSM state enum (IDLE, SERVE, DEAD).
- One sub-module, rr_arbiter6: combinational round-robin pick.
  - Inputs: req[5:0], last[2:0].
  - Outputs: one-hot gnt[5:0], index[2:0], valid.
- Needs are stored internally as an array indexed by the package constants and fanned out to the six named ports.

## Test plan
Run with TICK_DIV=4, ACTION_CYCLES=2, CARE_AMOUNT=4.
- Reset: rst pulse → all needs 0, grant 0, busy 0, dead 0. Assert rst mid-SERVE → grant drops in the same cycle, before the next clk edge.
- Decay: req=0 for 96 cycles (24 ticks) → every need = 4, and the increments occur in order hunger..social.
- Round-robin: req=6'b100001 held → grants in order 000001, 100000, 000001; each grant lasts 2 cycles with 1 idle cycle between grants; both needs decrement.
- Saturation: hygiene=2, request hygiene → hygiene=0. Tick and care on hunger=3 in the same final SERVE cycle → hunger=0.
- Death: drive hunger to 15 via decay with req=0 → dead=1 one cycle later. Needs stay frozen for 100 cycles, req=6'h3F yields no grant, and only rst clears dead.
- Abort: hygiene reaches 15 during a hunger SERVE → grant clears at the next edge and hunger is not decremented.
